// File: rtl/cla32_adder_reg.sv
// cla32_adder_reg: two-level carry-lookahead adder (a+b+cin) with registered sum, cout and signed overflow.
// Build option CLA_SATURATE_EN clamps the registered sum on signed overflow. WIDTH must be a multiple of GROUP.
module cla32_adder_reg #(
   parameter int WIDTH = 32,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             of
);

   localparam int NGRP = WIDTH / GROUP;

   // Carry into position n as a flat sum of products: no term waits on a lower carry.
   function automatic logic lookahead(input logic [WIDTH-1:0] g,
                                      input logic [WIDTH-1:0] p,
                                      input logic             c0,
                                      input int               n);
      logic c;
      logic t;
      c = 1'b0;
      for (int j = 0; j < WIDTH; j++) begin
         if (j < n) begin
            t = g[j];
            for (int m = 0; m < WIDTH; m++) begin
               if (m > j && m < n) t = t & p[m];
            end
            c = c | t;
         end
      end
      t = c0;
      for (int m = 0; m < WIDTH; m++) begin
         if (m < n) t = t & p[m];
      end
      return c | t;
   endfunction

`ifdef CLA_SATURATE_EN
   function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                 input logic             a_msb,
                                                 input logic             ovf);
      if (!ovf) return raw;
      return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   endfunction
`endif

   logic [WIDTH-1:0] w_g;
   logic [WIDTH-1:0] w_p;
   logic [WIDTH-1:0] w_c;
   logic [NGRP-1:0]  w_grp_g;
   logic [NGRP-1:0]  w_grp_p;
   logic [NGRP:0]    w_cg;
   logic [WIDTH-1:0] w_gg_x;
   logic [WIDTH-1:0] w_gp_x;
   logic [WIDTH-1:0] w_raw_sum;
   logic [WIDTH-1:0] w_next_sum;
   logic             w_cout;
   logic             w_of;

   assign w_g = a & b;
   assign w_p = a ^ b;

   // First level: group generate/propagate plus the carries inside each group.
   for (genvar k = 0; k < NGRP; k++) begin : g_grp
      logic [WIDTH-1:0] w_gx;
      logic [WIDTH-1:0] w_px;

      always_comb begin
         w_gx = '0;
         w_px = '0;
         w_gx[GROUP-1:0] = w_g[k*GROUP +: GROUP];
         w_px[GROUP-1:0] = w_p[k*GROUP +: GROUP];
      end

      assign w_grp_g[k] = lookahead(w_gx, w_px, 1'b0, GROUP);
      assign w_grp_p[k] = &w_p[k*GROUP +: GROUP];

      for (genvar i = 0; i < GROUP; i++) begin : g_bit
         assign w_c[k*GROUP + i] = lookahead(w_gx, w_px, w_cg[k], i);
      end
   end

   always_comb begin
      w_gg_x = '0;
      w_gp_x = '0;
      w_gg_x[NGRP-1:0] = w_grp_g;
      w_gp_x[NGRP-1:0] = w_grp_p;
   end

   // Second level: every group carry-in straight from group G/P and cin; the last one is cout.
   for (genvar k = 0; k <= NGRP; k++) begin : g_lcu
      assign w_cg[k] = lookahead(w_gg_x, w_gp_x, cin, k);
   end

   assign w_raw_sum = w_p ^ w_c;
   assign w_cout    = w_cg[NGRP];
   assign w_of      = w_c[WIDTH-1] ^ w_cout;

`ifdef CLA_SATURATE_EN
   assign w_next_sum = saturate(w_raw_sum, a[WIDTH-1], w_of);
`else
   assign w_next_sum = w_raw_sum;
`endif

   logic             r_valid;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_of;

   // Result flags hold across idle cycles; only out_valid drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_of    <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_sum  <= w_next_sum;
            r_cout <= w_cout;
            r_of   <= w_of;
         end
      end
   end

   assign out_valid = r_valid;
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign of        = r_of;

endmodule

// File: tb/tb_cla32_adder_reg.sv
// tb_cla32_adder_reg: directed vectors with hand-computed results, streaming, idle hold,
// asynchronous reset mid-stream and a random sweep against a+b+cin with the sign-rule overflow.
module tb_cla32_adder_reg;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        ci;
      logic [31:0] s;
      logic        co;
      logic        ov;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        cin = 1'b0;
   logic        out_valid;
   logic [31:0] sum;
   logic        cout;
   logic        of;

   int n_cmp = 0;
   int n_err = 0;

   vec_t vecs[14];

   always #5 clk = ~clk;

   cla32_adder_reg #(.WIDTH(32), .GROUP(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
      .out_valid(out_valid), .sum(sum), .cout(cout), .of(of)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_sum(input vec_t v);
      logic [31:0] e;
      e = v.s;
`ifdef CLA_SATURATE_EN
      if (v.ov) e = v.a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
      return e;
   endfunction

   task automatic check_out(input string tag, input vec_t v);
      chk({tag, ".vld"}, 32'(out_valid), 32'd1);
      chk({tag, ".sum"}, sum, exp_sum(v));
      chk({tag, ".cout"}, 32'(cout), 32'(v.co));
      chk({tag, ".of"}, 32'(of), 32'(v.ov));
   endtask

   task automatic drive(input vec_t v);
      a   = v.a;
      b   = v.b;
      cin = v.ci;
   endtask

   function automatic vec_t mkv(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                                input logic [31:0] vs, input logic vco, input logic vov);
      vec_t v;
      v.a = va; v.b = vb; v.ci = vc; v.s = vs; v.co = vco; v.ov = vov;
      return v;
   endfunction

   initial begin
      vec_t  v;
      vec_t  prev;
      logic [32:0] full;
      logic [31:0] r;

      vecs[0]  = mkv(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      vecs[1]  = mkv(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
      vecs[2]  = mkv(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFE, 1'b1, 1'b0);
      vecs[3]  = mkv(32'h0000_0001, 32'h8000_0000, 1'b0, 32'h8000_0001, 1'b0, 1'b0);
      vecs[4]  = mkv(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
      vecs[5]  = mkv(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
      vecs[6]  = mkv(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
      vecs[7]  = mkv(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
      vecs[8]  = mkv(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
      vecs[9]  = mkv(32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0);
      vecs[10] = mkv(32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0, 1'b0);
      vecs[11] = mkv(32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 32'h1000_0000, 1'b0, 1'b0);
      vecs[12] = mkv(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1, 1'b0);
      vecs[13] = mkv(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0);

      // power-on reset
      #1 rst = 1'b1;
      #2;
      chk("rst.vld", 32'(out_valid), 32'd0);
      chk("rst.sum", sum, 32'd0);
      chk("rst.cout", 32'(cout), 32'd0);
      chk("rst.of", 32'(of), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle.vld", 32'(out_valid), 32'd0);

      // directed vectors streamed back-to-back
      in_valid = 1'b1;
      drive(vecs[0]);
      for (int i = 1; i < 14; i++) begin
         @(negedge clk);
         check_out($sformatf("v%0d", i - 1), vecs[i - 1]);
         drive(vecs[i]);
      end
      @(negedge clk);
      check_out("v13", vecs[13]);
      in_valid = 1'b0;
      a = 32'hDEAD_BEEF;
      b = 32'h1111_1111;
      @(negedge clk);
      chk("hold.vld", 32'(out_valid), 32'd0);
      chk("hold.sum", sum, exp_sum(vecs[13]));
      chk("hold.cout", 32'(cout), 32'(vecs[13].co));
      chk("hold.of", 32'(of), 32'(vecs[13].ov));

      // single-op latency, then async reset between edges
      in_valid = 1'b1;
      drive(vecs[1]);
      @(negedge clk);
      check_out("lat", vecs[1]);
      drive(vecs[8]);
      #2 rst = 1'b1;
      #1;
      chk("arst.vld", 32'(out_valid), 32'd0);
      chk("arst.sum", sum, 32'd0);
      chk("arst.cout", 32'(cout), 32'd0);
      chk("arst.of", 32'(of), 32'd0);
      @(negedge clk);
      chk("arst_hold.vld", 32'(out_valid), 32'd0);
      chk("arst_hold.sum", sum, 32'd0);
      chk("arst_hold.of", 32'(of), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_out("post_rst", vecs[8]);

      // random sweep, streamed
      drive(vecs[0]);
      prev = vecs[0];
      for (int i = 0; i < 2000; i++) begin
         r = $urandom;
         v.a = $urandom;
         v.b = (i % 4 == 0) ? ~v.a : 32'($urandom);
         v.ci = r[0];
         full = {1'b0, v.a} + {1'b0, v.b} + {32'd0, v.ci};
         v.s = full[31:0];
         v.co = full[32];
         v.ov = (v.a[31] == v.b[31]) && (v.s[31] != v.a[31]);
         @(negedge clk);
         check_out($sformatf("rnd%0d", i), prev);
         drive(v);
         prev = v;
      end
      @(negedge clk);
      check_out("rnd_last", prev);
      in_valid = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
